// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the load/store unit: operation codes, FSM states,
// timeout default and small operation-classification helpers.
package mem_lsu_pkg;

   localparam int unsigned ACK_TIMEOUT_DEF = 16;

   typedef enum logic [3:0] {
      OP_NONE = 4'd0,
      OP_LB   = 4'd1,
      OP_LH   = 4'd2,
      OP_LW   = 4'd3,
      OP_LBU  = 4'd4,
      OP_LHU  = 4'd5,
      OP_SB   = 4'd6,
      OP_SH   = 4'd7,
      OP_SW   = 4'd8
   } mem_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUS  = 2'd1,
      ST_DONE = 2'd2
   } lsu_state_e;

   function automatic logic op_is_load(input logic [3:0] op);
      case (op)
         OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: return 1'b1;
         default:                            return 1'b0;
      endcase
   endfunction

   function automatic logic op_is_store(input logic [3:0] op);
      case (op)
         OP_SB, OP_SH, OP_SW: return 1'b1;
         default:             return 1'b0;
      endcase
   endfunction

   function automatic logic op_misaligned(input logic [3:0] op, input logic [1:0] a);
      case (op)
         OP_LH, OP_LHU, OP_SH: return a[0];
         OP_LW, OP_SW:         return (a != 2'b00);
         default:              return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// Data-bus interface between the load/store unit (master) and memory (slave).
interface mem_lsu_if;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [3:0]  bus_wstrb;
   logic        bus_ack;
   logic [31:0] bus_rdata;

   modport master (
      output bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
      input  bus_ack, bus_rdata
   );

   modport slave (
      input  bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
      output bus_ack, bus_rdata
   );
endinterface

// File: rtl/mem_lsu_align.sv
// lsu_align: combinational store strobe/lane replication and load byte/half
// extraction with sign or zero extension.
module mem_lsu_align
   import mem_lsu_pkg::*;
(
   input  logic [3:0]  i_op,
   input  logic [1:0]  i_addr_lo,
   input  logic [31:0] i_wdata,
   input  logic [31:0] i_rdata,
   output logic [3:0]  o_wstrb,
   output logic [31:0] o_wdata,
   output logic [31:0] o_ldata
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   // Pick the addressed byte and halfword lanes out of the read word.
   always_comb begin
      w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
      case (i_addr_lo)
         2'd0:    w_byte = i_rdata[7:0];
         2'd1:    w_byte = i_rdata[15:8];
         2'd2:    w_byte = i_rdata[23:16];
         2'd3:    w_byte = i_rdata[31:24];
         default: w_byte = 8'h00;
      endcase
   end

   // Per-operation strobe, replicated write data and extended load value.
   always_comb begin
      o_wstrb = 4'b0000;
      o_wdata = 32'h0000_0000;
      o_ldata = 32'h0000_0000;
      case (i_op)
         OP_SB: begin
            o_wstrb = 4'b0001 << i_addr_lo;
            o_wdata = {4{i_wdata[7:0]}};
         end
         OP_SH: begin
            o_wstrb = 4'b0011 << {i_addr_lo[1], 1'b0};
            o_wdata = {2{i_wdata[15:0]}};
         end
         OP_SW: begin
            o_wstrb = 4'b1111;
            o_wdata = i_wdata;
         end
         OP_LB:   o_ldata = {{24{w_byte[7]}}, w_byte};
         OP_LBU:  o_ldata = {24'h00_0000, w_byte};
         OP_LH:   o_ldata = {{16{w_half[15]}}, w_half};
         OP_LHU:  o_ldata = {16'h0000, w_half};
         OP_LW:   o_ldata = i_rdata;
         default: o_ldata = 32'h0000_0000;
      endcase
   end

endmodule

// File: rtl/mem_lsu.sv
// Load/store unit: IDLE/BUS/DONE sequencer with ack timeout driving a word bus.
// Optional LSU_MISALIGN_CHK_EN rejects misaligned halfword/word accesses.
module mem_lsu
   import mem_lsu_pkg::*;
#(
   parameter int unsigned ACK_TIMEOUT = ACK_TIMEOUT_DEF
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        i_valid_in,
   input  logic [3:0]  i_mem_op,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_wdata,
   output logic        o_stall,
   output logic        o_done,
   output logic [31:0] o_rdata,
   output logic        o_rdata_valid,
   output logic        o_misalign,
   output logic        o_bus_err,
   mem_lsu_if.master   bus
);

   lsu_state_e  r_state;
   lsu_state_e  w_next;
   logic [3:0]  r_op;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [7:0]  r_cnt;
   logic        r_err;
   logic [31:0] r_rdata;

   logic        w_in_bus;
   logic        w_can_take;
   logic        w_req_op;
   logic        w_misalign;
   logic        w_accept;
   logic        w_timeout;
   logic [3:0]  w_wstrb;
   logic [31:0] w_bwdata;
   logic [31:0] w_ldata;

   assign w_in_bus   = (r_state == ST_BUS);
   assign w_can_take = (r_state == ST_IDLE) || (r_state == ST_DONE);
   assign w_req_op   = i_valid_in && (op_is_load(i_mem_op) || op_is_store(i_mem_op));
`ifdef LSU_MISALIGN_CHK_EN
   assign w_misalign = w_req_op && w_can_take && op_misaligned(i_mem_op, i_addr[1:0]);
`else
   assign w_misalign = 1'b0;
`endif
   assign w_accept   = w_req_op && w_can_take && !w_misalign;
   assign w_timeout  = (r_cnt == 8'(ACK_TIMEOUT - 1));

   mem_lsu_align lsu_align (
      .i_op      (r_op),
      .i_addr_lo (r_addr[1:0]),
      .i_wdata   (r_wdata),
      .i_rdata   (bus.bus_rdata),
      .o_wstrb   (w_wstrb),
      .o_wdata   (w_bwdata),
      .o_ldata   (w_ldata)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state: an ack in the last allowed cycle still counts as success.
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) w_next = ST_BUS;
            else          w_next = ST_IDLE;
         end
         ST_BUS: begin
            if (bus.bus_ack || w_timeout) w_next = ST_DONE;
            else                          w_next = ST_BUS;
         end
         ST_DONE: begin
            if (w_accept) w_next = ST_BUS;
            else          w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   // Request capture, timeout counter, error flag and load result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_op    <= 4'd0;
         r_addr  <= 32'h0000_0000;
         r_wdata <= 32'h0000_0000;
         r_cnt   <= 8'd0;
         r_err   <= 1'b0;
         r_rdata <= 32'h0000_0000;
      end else if (w_accept) begin
         r_op    <= i_mem_op;
         r_addr  <= i_addr;
         r_wdata <= i_wdata;
         r_cnt   <= 8'd0;
         r_err   <= 1'b0;
      end else if (w_in_bus) begin
         if (bus.bus_ack) begin
            if (op_is_load(r_op)) r_rdata <= w_ldata;
         end else if (w_timeout) begin
            r_err <= 1'b1;
         end else begin
            r_cnt <= r_cnt + 8'd1;
         end
      end
   end

   assign o_stall       = w_accept || w_in_bus;
   assign o_done        = (r_state == ST_DONE);
   assign o_bus_err     = o_done && r_err;
   assign o_rdata_valid = o_done && !r_err && op_is_load(r_op);
   assign o_rdata       = r_rdata;
   assign o_misalign    = w_misalign;

   // Bus fields are only driven while a request is outstanding.
   assign bus.bus_req   = w_in_bus;
   assign bus.bus_we    = w_in_bus && op_is_store(r_op);
   assign bus.bus_addr  = w_in_bus ? {r_addr[31:2], 2'b00} : 32'h0000_0000;
   assign bus.bus_wdata = w_in_bus ? w_bwdata : 32'h0000_0000;
   assign bus.bus_wstrb = w_in_bus ? w_wstrb : 4'b0000;

endmodule

// File: tb/tb_mem_lsu.sv
// Scoreboard bench for mem_lsu: random op stream, bench-side bus slave and
// reference model predicting completion cycle, status pulses and load data.
module tb_mem_lsu;
   import mem_lsu_pkg::*;

   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid_in;
   logic [3:0]  mem_op;
   logic [31:0] addr, wdata;
   logic        o_stall, o_done, o_rdata_valid, o_misalign, o_bus_err;
   logic [31:0] o_rdata;

   mem_lsu_if bus();

   mem_lsu #(.ACK_TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .i_valid_in(valid_in), .i_mem_op(mem_op),
      .i_addr(addr), .i_wdata(wdata), .o_stall(o_stall), .o_done(o_done),
      .o_rdata(o_rdata), .o_rdata_valid(o_rdata_valid), .o_misalign(o_misalign),
      .o_bus_err(o_bus_err), .bus(bus)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          done_cyc;
      logic        err;
      logic        rv;
      logic [31:0] rdata;
   } exp_t;

   typedef struct {
      int          delay;
      logic [31:0] rd;
      logic [31:0] baddr;
      logic        we;
      logic [3:0]  strb;
      logic [31:0] bwd;
   } bus_t;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rd;
      int          delay;
      int          gap;
   } txn_t;

   exp_t sbq[$];
   bus_t bq[$];
   txn_t tq[$];

   int n_vec = 0, n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic is_ld(input logic [3:0] op);
      return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
   endfunction

   function automatic logic is_st(input logic [3:0] op);
      return op inside {OP_SB, OP_SH, OP_SW};
   endfunction

   function automatic logic misal(input logic [3:0] op, input logic [1:0] a);
`ifdef LSU_MISALIGN_CHK_EN
      return ((op inside {OP_LH, OP_LHU, OP_SH}) && (a % 2 != 0)) ||
             ((op inside {OP_LW, OP_SW}) && (a != 0));
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [31:0] ld_ext(input logic [3:0] op, input logic [1:0] a, input logic [31:0] rd);
      logic [31:0] b, h;
      b = (rd >> (8 * int'(a))) & 32'h0000_00FF;
      h = (rd >> (16 * int'(a / 2))) & 32'h0000_FFFF;
      case (op)
         OP_LB:   return (b >= 32'd128)   ? (b | 32'hFFFF_FF00) : b;
         OP_LBU:  return b;
         OP_LH:   return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
         OP_LHU:  return h;
         default: return rd;
      endcase
   endfunction

   function automatic logic [3:0] st_strb(input logic [3:0] op, input logic [1:0] a);
      case (op)
         OP_SB:   return 4'(1 << int'(a));
         OP_SH:   return (a >= 2'd2) ? 4'b1100 : 4'b0011;
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] st_data(input logic [3:0] op, input logic [31:0] wd);
      case (op)
         OP_SB:   return (wd & 32'h0000_00FF) * 32'h0101_0101;
         OP_SH:   return (wd & 32'h0000_FFFF) * 32'h0001_0001;
         default: return wd;
      endcase
   endfunction

   // Monitor: pops one expectation per done pulse.
   exp_t mon_e;
   always @(negedge clk) begin
      #2;
      if (!rst) begin
         if (o_done) begin
            if (sbq.size() == 0) begin
               chk("spurious_done", {31'd0, o_done}, 32'd0);
            end else begin
               mon_e = sbq.pop_front();
               chk("done_cycle", cyc, mon_e.done_cyc);
               chk("bus_err", {31'd0, o_bus_err}, {31'd0, mon_e.err});
               chk("rdata_valid", {31'd0, o_rdata_valid}, {31'd0, mon_e.rv});
               chk("rdata", o_rdata, mon_e.rdata);
            end
         end else begin
            chk("idle_pulses", {30'd0, o_bus_err, o_rdata_valid}, 32'd0);
         end
      end
   end

   // Driver / bus-slave / model state.
   logic        m_busy = 1'b0;
   int          m_done_cyc = 0;
   logic [31:0] m_last = 32'd0;
   txn_t        cur;
   logic        have_cur = 1'b0;
   int          gap_left = 0;
   int          bus_cnt = 0;

   task automatic step();
      logic present, mis, acc, err;
      bus_t b;
      exp_t e;
      @(negedge clk);
      bus.bus_ack = 1'b0;
      bus.bus_rdata = $urandom;
      if (bus.bus_req) begin
         if (bq.size() == 0) begin
            chk("bus_unexpected", {31'd0, bus.bus_req}, 32'd0);
         end else begin
            chk("bus_addr", bus.bus_addr, bq[0].baddr);
            chk("bus_we", {31'd0, bus.bus_we}, {31'd0, bq[0].we});
            if (bq[0].we) begin
               chk("bus_wstrb", {28'd0, bus.bus_wstrb}, {28'd0, bq[0].strb});
               chk("bus_wdata", bus.bus_wdata, bq[0].bwd);
            end
            if (bus_cnt == bq[0].delay) begin
               bus.bus_ack = 1'b1;
               bus.bus_rdata = bq[0].rd;
            end
            bus_cnt++;
         end
      end else if (bus_cnt != 0) begin
         void'(bq.pop_front());
         bus_cnt = 0;
      end

      if (m_busy && cyc > m_done_cyc) m_busy = 1'b0;
      if (!have_cur && tq.size() > 0) begin
         cur = tq.pop_front();
         have_cur = 1'b1;
         gap_left = cur.gap;
      end
      present = have_cur && (gap_left == 0);
      if (have_cur && gap_left > 0) gap_left--;
      valid_in = present;
      mem_op   = present ? cur.op    : 4'($urandom_range(0, 8));
      addr     = present ? cur.addr  : $urandom;
      wdata    = present ? cur.wdata : $urandom;
      #1;
      mis = present && (cur.op != OP_NONE) && (!m_busy || cyc == m_done_cyc) &&
            misal(cur.op, cur.addr[1:0]);
      acc = present && (cur.op != OP_NONE) && (!m_busy || cyc == m_done_cyc) && !mis;
      chk("stall", {31'd0, o_stall}, {31'd0, acc || (m_busy && cyc < m_done_cyc)});
      chk("misalign", {31'd0, o_misalign}, {31'd0, mis});
      if (acc) begin
         err = (cur.delay >= TO);
         b.delay = cur.delay;
         b.rd    = cur.rd;
         b.baddr = cur.addr & 32'hFFFF_FFFC;
         b.we    = is_st(cur.op);
         b.strb  = st_strb(cur.op, cur.addr[1:0]);
         b.bwd   = st_data(cur.op, cur.wdata);
         bq.push_back(b);
         if (is_ld(cur.op) && !err) m_last = ld_ext(cur.op, cur.addr[1:0], cur.rd);
         e.done_cyc = err ? (cyc + 1 + TO) : (cyc + 2 + cur.delay);
         e.err   = err;
         e.rv    = is_ld(cur.op) && !err;
         e.rdata = m_last;
         sbq.push_back(e);
         m_busy = 1'b1;
         m_done_cyc = e.done_cyc;
         have_cur = 1'b0;
      end else if (present) begin
         if (cur.op == OP_NONE || mis) have_cur = 1'b0;
      end
   endtask

   task automatic add(input logic [3:0] op, input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] rd, input int delay, input int gap);
      txn_t t;
      t.op = op; t.addr = a; t.wdata = wd; t.rd = rd; t.delay = delay; t.gap = gap;
      tq.push_back(t);
   endtask

   task automatic drain();
      int guard = 0;
      while ((tq.size() > 0 || have_cur || m_busy) && guard < 20000) begin
         step();
         guard++;
      end
      if (guard >= 20000) chk("drain_timeout", 32'(guard), 32'd0);
      repeat (2) step();
   endtask

   initial begin
      rst = 1'b1;
      valid_in = 1'b0; mem_op = 4'd0; addr = 32'd0; wdata = 32'd0;
      bus.bus_ack = 1'b0; bus.bus_rdata = 32'd0;
      repeat (3) @(negedge clk);
      chk("rst_outputs", {26'd0, o_stall, o_done, o_rdata_valid, o_misalign, o_bus_err, bus.bus_req}, 32'd0);
      chk("rst_rdata", o_rdata, 32'd0);
      rst = 1'b0;

      add(OP_LB,  32'h0000_0103, 32'h0,         32'h80FF_1234, 0,  0);
      add(OP_SH,  32'h0000_0202, 32'h0000_ABCD, 32'h0,         0,  0);
      add(OP_LW,  32'h0000_0400, 32'h0,         32'h1111_2222, TO, 0);
      add(OP_SW,  32'h0000_0408, 32'hCAFE_F00D, 32'h0,         TO - 1, 1);
      add(OP_LBU, 32'h0000_0005, 32'h0,         32'h00F0_A500, 0,  0);
      add(OP_LBU, 32'h0000_0006, 32'h0,         32'h00F0_A500, 0,  0);
      add(OP_NONE, 32'h0, 32'h0, 32'h0, 0, 0);
      for (int i = 0; i < 80; i++) begin
         int r, d;
         r = $urandom_range(0, 9);
         d = (r == 0) ? TO + $urandom_range(0, 3) : (r == 1) ? TO - 1 : $urandom_range(0, 3);
         add(4'($urandom_range(0, 8)), $urandom, $urandom, $urandom, d,
             ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0);
      end
      drain();

      // Reset while a request is outstanding on the bus.
      add(OP_LW, 32'h0000_0800, 32'h0, 32'h0, 100, 0);
      step();
      step();
      chk("bus_req_before_rst", {31'd0, bus.bus_req}, 32'd1);
      rst = 1'b1;
      #1;
      chk("rst_bus_req", {31'd0, bus.bus_req}, 32'd0);
      chk("rst_mid_outputs", {28'd0, o_stall, o_done, o_rdata_valid, o_bus_err}, 32'd0);
      chk("rst_mid_rdata", o_rdata, 32'd0);
      sbq.delete(); bq.delete(); tq.delete();
      bus_cnt = 0; m_busy = 1'b0; m_last = 32'd0; have_cur = 1'b0;
      bus.bus_ack = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
      add(OP_LHU, 32'h0000_0002, 32'h0, 32'h8001_0000, 0, 0);
      add(OP_LH,  32'h0000_0002, 32'h0, 32'h8001_0000, 2, 0);
      drain();

      chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
